// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder path.
package systolic_pkg;

  localparam int SYSTOLIC_ARRAY_WIDTH = 2;
  localparam int DATA_WIDTH           = 16;
  localparam int SKEW_DEPTH           = SYSTOLIC_ARRAY_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD_W,
    ST_SWITCH,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  // Number of array columns actually used by a tile.
  function automatic logic [15:0] clamp_cols(input logic [15:0] cols,
                                             input logic [15:0] max_cols);
    return (cols > max_cols) ? max_cols : cols;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Per-lane delay chain (data + valid) of DEPTH registers; idle slots carry zero.
module systolic_skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      // Bubbles enter as zero data so the array never sees stale operands.
      data_q[0]  <= in_valid ? in_data : '0;
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit-side driver for the 2x2 systolic array: column config, weight load,
// shadow switch and skewed activation streaming for one tile per command.
module systolic_feeder #(
  parameter int SYSTOLIC_ARRAY_WIDTH = systolic_pkg::SYSTOLIC_ARRAY_WIDTH,
  parameter int DATA_WIDTH           = systolic_pkg::DATA_WIDTH,
  parameter int ROW_CNT_WIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ROW_CNT_WIDTH-1:0] cmd_num_rows,
  input  logic [15:0]              cmd_num_cols,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DATA_WIDTH-1:0]    w_data_1,
  input  logic [DATA_WIDTH-1:0]    w_data_2,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [DATA_WIDTH-1:0]    act_data_1,
  input  logic [DATA_WIDTH-1:0]    act_data_2,
  output logic [DATA_WIDTH-1:0]    sys_data_in_1x,
  output logic [DATA_WIDTH-1:0]    sys_data_in_2x,
  output logic                     sys_start,
  output logic [DATA_WIDTH-1:0]    sys_weight_in_x1,
  output logic [DATA_WIDTH-1:0]    sys_weight_in_x2,
  output logic                     sys_accept_w_1,
  output logic                     sys_accept_w_2,
  output logic                     sys_switch_in,
  output logic [15:0]              ub_rd_col_size_in,
  output logic                     ub_rd_col_size_valid_in,
  output logic                     busy,
  output logic                     done
);

  import systolic_pkg::*;

  // Handshakes: a beat transfers on a rising clk edge where valid && ready.
  // Ready outputs are registered from the next state, so they equal the
  // current state's permission; upstream data is sampled only on transfer.

  localparam int DRAIN_W = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;

  feeder_state_t state, state_next;

  logic [ROW_CNT_WIDTH-1:0] num_rows;
  logic [ROW_CNT_WIDTH-1:0] rows_sent;
  logic [15:0]              eff_cols;
  logic                     beat;
  logic [DRAIN_W-1:0]       drain_cnt;

  logic cmd_fire, w_fire, act_fire, last_row, drain_last;
  logic                  lane2_valid;
  logic [DATA_WIDTH-1:0] lane2_data;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign w_fire     = w_valid && w_ready;
  assign act_fire   = act_valid && act_ready;
  assign last_row   = (rows_sent == (num_rows - ROW_CNT_WIDTH'(1)));
  assign drain_last = (drain_cnt == DRAIN_W'(SKEW_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (cmd_fire) state_next = ST_CFG;
      ST_CFG:    state_next = ST_LOAD_W;
      ST_LOAD_W: if (w_fire && beat) state_next = ST_SWITCH;
      ST_SWITCH: state_next = (num_rows == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (act_fire && last_row) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_last) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Tile bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows  <= '0;
      rows_sent <= '0;
      eff_cols  <= '0;
      beat      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (cmd_fire) begin
        num_rows  <= cmd_num_rows;
        eff_cols  <= clamp_cols(cmd_num_cols, 16'(SYSTOLIC_ARRAY_WIDTH));
        rows_sent <= '0;
        beat      <= 1'b0;
      end
      if (w_fire)   beat      <= ~beat;
      if (act_fire) rows_sent <= rows_sent + ROW_CNT_WIDTH'(1);
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  // Registered control and weight outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready               <= 1'b0;
      w_ready                 <= 1'b0;
      act_ready               <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      ub_rd_col_size_in       <= '0;
      ub_rd_col_size_valid_in <= 1'b0;
      sys_weight_in_x1        <= '0;
      sys_weight_in_x2        <= '0;
      sys_accept_w_1          <= 1'b0;
      sys_accept_w_2          <= 1'b0;
      sys_switch_in           <= 1'b0;
    end else begin
      cmd_ready               <= (state_next == ST_IDLE);
      w_ready                 <= (state_next == ST_LOAD_W);
      act_ready               <= (state_next == ST_STREAM);
      busy                    <= (state_next != ST_IDLE);
      done                    <= (state == ST_DONE);
      ub_rd_col_size_valid_in <= (state == ST_CFG);
      ub_rd_col_size_in       <= (state == ST_CFG) ? eff_cols : '0;
      // Column c only shifts when it is part of the active tile.
      sys_accept_w_1          <= w_fire && (eff_cols >= 16'd1);
      sys_accept_w_2          <= w_fire && (eff_cols >= 16'd2);
      if (w_fire) begin
        sys_weight_in_x1 <= w_data_1;
        sys_weight_in_x2 <= w_data_2;
      end
      // Registered from SWITCH so it lands strictly after the last accept_w.
      sys_switch_in           <= (state == ST_SWITCH);
    end
  end

  systolic_skew_line #(.DEPTH(1), .WIDTH(DATA_WIDTH)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (act_fire),
    .in_data   (act_data_1),
    .out_valid (sys_start),
    .out_data  (sys_data_in_1x)
  );

  systolic_skew_line #(.DEPTH(SKEW_DEPTH + 1), .WIDTH(DATA_WIDTH)) u_lane2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (act_fire),
    .in_data   (act_data_2),
    .out_valid (lane2_valid),
    .out_data  (lane2_data)
  );

  assign sys_data_in_2x = lane2_valid ? lane2_data : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed tile table, hand-written reset/backpressure
// sequences and random tiles, checked cycle by cycle against a reference model.
module tb_systolic_feeder;

  localparam int TMO = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_num_rows, cmd_num_cols;
  logic        w_valid, w_ready;
  logic [15:0] w_data_1, w_data_2;
  logic        act_valid, act_ready;
  logic [15:0] act_data_1, act_data_2;
  logic [15:0] sys_data_in_1x, sys_data_in_2x;
  logic        sys_start;
  logic [15:0] sys_weight_in_x1, sys_weight_in_x2;
  logic        sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [15:0] ub_rd_col_size_in;
  logic        ub_rd_col_size_valid_in, busy, done;

  systolic_feeder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_rows(cmd_num_rows), .cmd_num_cols(cmd_num_cols),
    .w_valid(w_valid), .w_ready(w_ready), .w_data_1(w_data_1), .w_data_2(w_data_2),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_data_1(act_data_1), .act_data_2(act_data_2),
    .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x),
    .sys_start(sys_start),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_in(ub_rd_col_size_in),
    .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .busy(busy), .done(done)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  typedef struct { logic [15:0] w1; logic [15:0] w2; logic [1:0] mask; } wexp_t;

  // Expected array-side activity keyed by the cycle it must be visible in.
  wexp_t       exp_w [int];
  logic [15:0] exp1  [int];
  logic [15:0] exp2  [int];
  logic [15:0] exp_col_q [$];
  logic [15:0] last_w1 = '0, last_w2 = '0;
  int last_acc_cyc = 0;
  int obs_col, obs_acc1, obs_acc2, obs_start, obs_switch, obs_done, obs_ar;
  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit e;
      chk("cmd_ready_vs_busy", 32'(cmd_ready && busy), 0);
      if (ub_rd_col_size_valid_in) begin
        obs_col = ub_rd_col_size_in;
        if (exp_col_q.size() == 0) chk("col_strobe_extra", 1, 0);
        else chk("col_size", ub_rd_col_size_in, exp_col_q.pop_front());
      end
      if (exp_w.exists(cyc)) begin
        chk("accept_w", {sys_accept_w_2, sys_accept_w_1}, exp_w[cyc].mask);
        chk("weight_x1", sys_weight_in_x1, exp_w[cyc].w1);
        chk("weight_x2", sys_weight_in_x2, exp_w[cyc].w2);
        last_w1 = exp_w[cyc].w1;
        last_w2 = exp_w[cyc].w2;
        exp_w.delete(cyc);
      end else begin
        chk("accept_w_idle", {sys_accept_w_2, sys_accept_w_1}, 0);
        chk("weight_hold_x1", sys_weight_in_x1, last_w1);
        chk("weight_hold_x2", sys_weight_in_x2, last_w2);
      end
      obs_acc1 += int'(sys_accept_w_1);
      obs_acc2 += int'(sys_accept_w_2);
      if (sys_switch_in) begin
        obs_switch++;
        chk("switch_after_weights", 32'(cyc > last_acc_cyc), 1);
      end
      e = exp1.exists(cyc);
      chk("sys_start", sys_start, e);
      chk("data_in_1x", sys_data_in_1x, e ? exp1[cyc] : 16'd0);
      chk("data_in_2x", sys_data_in_2x, exp2.exists(cyc) ? exp2[cyc] : 16'd0);
      if (e) exp1.delete(cyc);
      if (exp2.exists(cyc)) exp2.delete(cyc);
      if (sys_start) begin
        obs_start++;
        chk("switch_before_data", obs_switch, 1);
      end
      if (act_ready) obs_ar++;
      if (done) begin
        obs_done++;
        chk("done_after_data", exp1.num() + exp2.num(), 0);
      end
    end
  end

  // ---------------- drivers ----------------
  logic [15:0] t_w [4];
  logic [15:0] t_a1 [16];
  logic [15:0] t_a2 [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 2)) : g;
  endfunction

  task automatic send_cmd(input int rows, input int cols);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_num_rows = 16'(rows);
    cmd_num_cols = 16'(cols);
    for (int i = 0; i < TMO && !ok; i++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept_timeout", 32'(ok), 1);
  endtask

  task automatic send_w(input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] mask);
    bit ok = 1'b0;
    w_valid = 1'b1;
    w_data_1 = d1;
    w_data_2 = d2;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (w_ready) begin
        ok = 1'b1;
        exp_w[cyc + 1] = '{w1: d1, w2: d2, mask: mask};
        last_acc_cyc = cyc + 1;
      end
      tick();
    end
    w_valid = 1'b0;
    w_data_1 = 16'($urandom);
    w_data_2 = 16'($urandom);
    chk("w_accept_timeout", 32'(ok), 1);
  endtask

  task automatic send_act(input logic [15:0] a1, input logic [15:0] a2);
    bit ok = 1'b0;
    act_valid = 1'b1;
    act_data_1 = a1;
    act_data_2 = a2;
    for (int i = 0; i < TMO && !ok; i++) begin
      if (act_ready) begin
        ok = 1'b1;
        exp1[cyc + 1] = a1;
        exp2[cyc + 2] = a2;
      end
      tick();
    end
    act_valid = 1'b0;
    act_data_1 = 16'($urandom);
    act_data_2 = 16'($urandom);
    chk("act_accept_timeout", 32'(ok), 1);
  endtask

  task automatic fill_tile(input bit fixed);
    for (int i = 0; i < 4; i++) t_w[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      t_a1[i] = 16'($urandom_range(1, 65535));
      t_a2[i] = 16'($urandom);
    end
    if (fixed) begin
      t_w[0] = 16'd5; t_w[1] = 16'd6; t_w[2] = 16'd7; t_w[3] = 16'd8;
      t_a1[0] = 16'd1; t_a2[0] = 16'd2;
      t_a1[1] = 16'd3; t_a2[1] = 16'd4;
      t_a1[2] = 16'd9; t_a2[2] = 16'd10;
    end
  endtask

  task automatic run_tile(input int rows, input int cols, input int w_gap,
                          input int a_gap, input bit hold_cmd);
    int eff;
    logic [1:0] mask;
    eff  = (cols > 2) ? 2 : cols;
    mask = {eff >= 2, eff >= 1};
    obs_col = -1; obs_acc1 = 0; obs_acc2 = 0; obs_start = 0;
    obs_switch = 0; obs_done = 0; obs_ar = 0;
    exp_col_q.push_back(16'(eff));
    send_cmd(rows, cols);
    if (hold_cmd) begin
      cmd_valid = 1'b1;
      cmd_num_rows = 16'($urandom);
      repeat (2) begin
        chk("cmd_ready_while_busy", cmd_ready, 0);
        chk("busy_in_tile", busy, 1);
        tick();
      end
    end
    send_w(t_w[0], t_w[1], mask);
    repeat (gap(w_gap)) tick();
    send_w(t_w[2], t_w[3], mask);
    cmd_valid = 1'b0;
    for (int r = 0; r < rows; r++) begin
      if (r > 0) repeat (gap(a_gap)) tick();
      send_act(t_a1[r], t_a2[r]);
    end
    for (int i = 0; i < TMO && obs_done == 0; i++) tick();
    chk("done_seen", obs_done, 1);
    repeat (2) tick();
    chk("done_single_pulse", obs_done, 1);
    chk("switch_single_pulse", obs_switch, 1);
    chk("col_strobe_consumed", exp_col_q.size(), 0);
    chk("act_ready_rule", 32'((rows == 0) ? (obs_ar == 0) : (obs_ar >= rows)), 1);
    chk("idle_after_tile", {busy, cmd_ready}, 2'b01);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int rows; int cols; int w_gap; int a_gap; bit hold; bit fixed;
    int e_col; int e_acc1; int e_acc2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{rows: 3, cols: 2, w_gap: 0, a_gap: 0, hold: 0, fixed: 1, e_col: 2, e_acc1: 2, e_acc2: 2};
    vecs[1] = '{rows: 2, cols: 1, w_gap: 0, a_gap: 0, hold: 0, fixed: 0, e_col: 1, e_acc1: 2, e_acc2: 0};
    vecs[2] = '{rows: 2, cols: 5, w_gap: 0, a_gap: 0, hold: 0, fixed: 0, e_col: 2, e_acc1: 2, e_acc2: 2};
    vecs[3] = '{rows: 2, cols: 2, w_gap: 0, a_gap: 1, hold: 0, fixed: 0, e_col: 2, e_acc1: 2, e_acc2: 2};
    vecs[4] = '{rows: 0, cols: 2, w_gap: 0, a_gap: 0, hold: 0, fixed: 0, e_col: 2, e_acc1: 2, e_acc2: 2};
    vecs[5] = '{rows: 1, cols: 2, w_gap: 3, a_gap: 0, hold: 1, fixed: 0, e_col: 2, e_acc1: 2, e_acc2: 2};
    vecs[6] = '{rows: 3, cols: 0, w_gap: 0, a_gap: 0, hold: 0, fixed: 0, e_col: 0, e_acc1: 0, e_acc2: 0};

    cmd_valid = 0; cmd_num_rows = 0; cmd_num_cols = 0;
    w_valid = 0; w_data_1 = 0; w_data_2 = 0;
    act_valid = 0; act_data_1 = 0; act_data_2 = 0;

    // Reset state: every output low, then cmd_ready once released.
    repeat (3) tick();
    chk("reset_ctrl_zero", {cmd_ready, w_ready, act_ready, busy, done, sys_start,
                            sys_switch_in, sys_accept_w_1, sys_accept_w_2,
                            ub_rd_col_size_valid_in}, 0);
    chk("reset_data_zero", sys_data_in_1x | sys_data_in_2x | sys_weight_in_x1 |
                           sys_weight_in_x2 | ub_rd_col_size_in, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      fill_tile(vecs[v].fixed);
      run_tile(vecs[v].rows, vecs[v].cols, vecs[v].w_gap, vecs[v].a_gap, vecs[v].hold);
      chk($sformatf("vec%0d_col_size", v), obs_col, vecs[v].e_col);
      chk($sformatf("vec%0d_accept_w_1", v), obs_acc1, vecs[v].e_acc1);
      chk($sformatf("vec%0d_accept_w_2", v), obs_acc2, vecs[v].e_acc2);
      chk($sformatf("vec%0d_starts", v), obs_start, vecs[v].rows);
    end

    // Reset in the middle of STREAM after 1 of 3 rows.
    fill_tile(1'b0);
    obs_switch = 0; obs_done = 0;
    exp_col_q.push_back(16'd2);
    send_cmd(3, 2);
    send_w(t_w[0], t_w[1], 2'b11);
    send_w(t_w[2], t_w[3], 2'b11);
    send_act(t_a1[0], t_a2[0]);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("midreset_ctrl_zero", {cmd_ready, w_ready, act_ready, busy, done, sys_start,
                               sys_switch_in, sys_accept_w_1, sys_accept_w_2,
                               ub_rd_col_size_valid_in}, 0);
    chk("midreset_data_zero", sys_data_in_1x | sys_data_in_2x | sys_weight_in_x1 |
                              sys_weight_in_x2 | ub_rd_col_size_in, 0);
    rst = 1'b0;
    tick();
    chk("midreset_idle", {cmd_ready, busy, w_ready, act_ready}, 4'b1000);
    exp1.delete(); exp2.delete(); exp_w.delete(); exp_col_q.delete();
    last_w1 = '0; last_w2 = '0; last_acc_cyc = 0;
    mon_en = 1'b1;
    fill_tile(1'b0);
    run_tile(2, 2, 0, 0, 0);
    chk("post_reset_starts", obs_start, 2);
    chk("post_reset_accepts", obs_acc1 + obs_acc2, 4);

    // Random tiles with random gaps and clamp values.
    for (int n = 0; n < 10; n++) begin
      int rows, cols, eff;
      rows = $urandom_range(0, 12);
      cols = $urandom_range(0, 4);
      eff  = (cols > 2) ? 2 : cols;
      fill_tile(1'b0);
      run_tile(rows, cols, -1, -1, 1'($urandom_range(0, 1)));
      chk("rnd_col_size", obs_col, eff);
      chk("rnd_accept_w_1", obs_acc1, (eff >= 1) ? 2 : 0);
      chk("rnd_accept_w_2", obs_acc2, (eff >= 2) ? 2 : 0);
      chk("rnd_starts", obs_start, rows);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
